// File: rtl/mdu_sequencer_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Holds the sequencer state encoding, the datapath width and the MDU funct codes.
package mdu_sequencer_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIVU  = 6'h1B;
  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MFLO  = 6'h12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
// acc_hi holds product-high / remainder, acc_lo holds multiplier / dividend-then-quotient.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] op_i,
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  output logic [WIDTH-1:0] acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum    = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, op_i} : {(WIDTH+1){1'b0}});
    rem_sh = {acc_hi_i, acc_lo_i[WIDTH-1]};
    // The remainder stays below the divisor, so a successful subtract always fits in WIDTH bits.
    diff   = rem_sh[WIDTH-1:0] - op_i;
    ge     = rem_sh >= {1'b0, op_i};
    if (is_div_i) begin
      acc_hi_o = ge ? diff : rem_sh[WIDTH-1:0];
      acc_lo_o = {acc_lo_i[WIDTH-2:0], ge};
    end else begin
      acc_hi_o = sum[WIDTH:1];
      acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// 32-step MULTU/DIVU sequencer owning the architectural HI/LO registers.
// HI/LO only change at completion, so hilo_out never exposes partial results.
module mdu_sequencer #(
  parameter int WIDTH = mdu_sequencer_pkg::WIDTH
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             rd_req,
  input  logic             hi_lo,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero
);
  import mdu_sequencer_pkg::*;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] step_hi, step_lo;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (state_q == DIV),
    .op_i     (op_q),
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .acc_hi_o (step_hi),
    .acc_lo_o (step_lo)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        // Multiply has priority; a simultaneous divide is simply not taken.
        if (start_mul) begin
          op_d     = opa;
          acc_hi_d = '0;
          acc_lo_d = opb;
          cnt_d    = 5'd31;
          state_d  = MUL;
        end else if (start_div) begin
          if (opb == '0) begin
            hi_d   = opa;
            lo_d   = '1;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            op_d     = opb;
            acc_hi_d = '0;
            acc_lo_d = opa;
            cnt_d    = 5'd31;
            dz_d     = 1'b0;
            state_d  = DIV;
          end
        end
      end
      MUL, DIV: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        if (cnt_q == 5'd0) begin
          hi_d    = step_hi;
          lo_d    = step_lo;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      op_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign stall    = busy & (rd_req | start_mul | start_div);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hilo_out = hi_lo ? lo_q : hi_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: issued ops push expected HI/LO/div_zero,
// a monitor pops and compares on every done pulse; directed checks cover timing and stall.
module tb_mdu_sequencer;

  logic        Clk = 1'b0;
  logic        reset;
  logic        start_mul, start_div, rd_req, hi_lo;
  logic [31:0] opa, opb;
  logic [31:0] hilo_out;
  logic        busy, stall, done, div_zero;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  mdu_sequencer #(.WIDTH(32)) dut (
    .Clk      (Clk),
    .reset    (reset),
    .start_mul(start_mul),
    .start_div(start_div),
    .opa      (opa),
    .opb      (opb),
    .rd_req   (rd_req),
    .hi_lo    (hi_lo),
    .hilo_out (hilo_out),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!reset && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_hilo_out", hilo_out, hi_lo ? e.lo : e.hi);
        check("sb_div_zero", {31'd0, div_zero}, {31'd0, e.dz});
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic issue(input logic mul, input logic [31:0] a, input logic [31:0] b);
    tick();
    start_mul = mul;
    start_div = ~mul;
    opa = a;
    opb = b;
    tick();
    start_mul = 1'b0;
    start_div = 1'b0;
  endtask

  // Returns at the negedge of the done cycle; busy_cycles counts busy cycles before it.
  task automatic wait_done(input string name, output int busy_cycles);
    bit found = 0;
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (done === 1'b1) begin
        found = 1;
        break;
      end
      if (busy === 1'b1) busy_cycles++;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 100 cycles", name);
    end
  endtask

  initial begin
    int nb;
    int stall_bad;
    int part_bad;
    bit found;

    reset = 1'b1;
    start_mul = 1'b0;
    start_div = 1'b0;
    rd_req = 1'b0;
    hi_lo = 1'b0;
    opa = '0;
    opb = '0;
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_div_zero", {31'd0, div_zero}, 32'd0);
    check("rst_hi", hilo_out, 32'd0);
    hi_lo = 1'b1;
    #1;
    check("rst_lo", hilo_out, 32'd0);
    #10 reset = 1'b0;

    // MULTU max x max, HI read through the scoreboard, LO directly afterwards.
    hi_lo = 1'b0;
    sb.push_back('{hi: 32'hFFFFFFFE, lo: 32'h00000001, dz: 1'b0});
    issue(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("mul_max", nb);
    check("mul_max_busy_cycles", nb, 32);
    @(negedge Clk);
    check("mul_max_done_single", {31'd0, done}, 32'd0);
    hi_lo = 1'b1;
    #1;
    check("mul_max_lo", hilo_out, 32'h00000001);

    // DIVU 100/7
    sb.push_back('{hi: 32'd2, lo: 32'd14, dz: 1'b0});
    issue(1'b0, 32'd100, 32'd7);
    wait_done("div_100_7", nb);
    check("div_100_7_busy_cycles", nb, 32);
    hi_lo = 1'b0;
    #1;
    check("div_100_7_hi", hilo_out, 32'd2);

    // DIVU by zero completes immediately without going busy.
    hi_lo = 1'b1;
    sb.push_back('{hi: 32'h1234, lo: 32'hFFFFFFFF, dz: 1'b1});
    issue(1'b0, 32'h1234, 32'd0);
    wait_done("div_zero", nb);
    check("div_zero_busy_cycles", nb, 0);
    check("div_zero_busy_at_done", {31'd0, busy}, 32'd0);
    hi_lo = 1'b0;
    #1;
    check("div_zero_hi", hilo_out, 32'h1234);

    // MFHI raised during MULTU 3x5: stalls, old HI stays visible, result in done cycle.
    sb.push_back('{hi: 32'd0, lo: 32'd15, dz: 1'b1});
    issue(1'b1, 32'd3, 32'd5);
    for (int i = 0; i < 4; i++) tick();
    rd_req = 1'b1;
    stall_bad = 0;
    part_bad = 0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (done === 1'b1) begin
        found = 1;
        break;
      end
      if (stall !== 1'b1) stall_bad++;
      if (hilo_out !== 32'h1234) part_bad++;
    end
    check("mfhi_found_done", {31'd0, found}, 32'd1);
    check("mfhi_stall_while_busy", stall_bad, 0);
    check("mfhi_no_partial", part_bad, 0);
    check("mfhi_stall_at_done", {31'd0, stall}, 32'd0);
    #1;
    hi_lo = 1'b1;
    #1;
    check("mfhi_lo", hilo_out, 32'd15);
    tick();
    rd_req = 1'b0;

    // start_div held while MUL busy: ignored until IDLE, then taken in the done cycle.
    sb.push_back('{hi: 32'd0, lo: 32'd42, dz: 1'b1});
    sb.push_back('{hi: 32'd2, lo: 32'd3, dz: 1'b0});
    issue(1'b1, 32'd7, 32'd6);
    start_div = 1'b1;
    opa = 32'd20;
    opb = 32'd6;
    @(negedge Clk);
    check("hold_div_stall", {31'd0, stall}, 32'd1);
    wait_done("hold_mul", nb);
    check("hold_mul_busy_cycles", nb, 31);
    check("hold_stall_at_done", {31'd0, stall}, 32'd0);
    tick();
    start_div = 1'b0;
    wait_done("hold_div", nb);
    check("hold_div_busy_cycles", nb, 32);
    check("hold_div_zero_cleared", {31'd0, div_zero}, 32'd0);

    // Asynchronous reset at step 10 of a MULTU.
    issue(1'b1, 32'hFFFF, 32'h10);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_lo", hilo_out, 32'd0);
    hi_lo = 1'b0;
    #1;
    check("arst_hi", hilo_out, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    #1;
    reset = 1'b0;
    hi_lo = 1'b1;
    sb.push_back('{hi: 32'd0, lo: 32'd3, dz: 1'b0});
    issue(1'b0, 32'd9, 32'd3);
    wait_done("div_9_3", nb);
    hi_lo = 1'b0;
    #1;
    check("div_9_3_hi", hilo_out, 32'd0);

    repeat (3) tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
